// File: rtl/cache_pkg.sv
// Shared cache constants, the fill-state type and the index-to-one-hot helper.
// Used by the way-fill decoder and by the way-hit encoder on the lookup side.
package cache_pkg;

    localparam int WAYS   = 8;
    localparam int IDX_W  = 3;
    localparam int BEATS  = 4;
    localparam int BEAT_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // One-hot word with only bit 'idx' set.
    function automatic logic [WAYS-1:0] way_onehot(input logic [IDX_W-1:0] idx);
        way_onehot      = '0;
        way_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/way_onehot_dec.sv
// Binary way index to one-hot decoder. The output is all zeros when en is low.
module way_onehot_dec #(
    parameter int WAYS  = 8,
    parameter int IDX_W = 3
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [WAYS-1:0]  onehot
);

    // Compare the index against every way number; at most one bit can match.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (en && (idx == IDX_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/way_fill_decoder.sv
// Way fill decoder: accepts a binary way index and drives a one-hot write
// enable into the data RAM banks for BEATS beats of a line fill.
//
// Optional build macro WAY_FILL_LAST_EN adds the last_way output, which
// holds the way of the most recently completed fill (MRU hint).
//
// Request handshake: a request transfers on a rising edge where req_valid
// and req_ready are both high. req_ready is high exactly while idle. A
// transferred request with req_en=0 is consumed without starting a fill.
//
// Beat timing: all outputs are registered. The value of beat_stall seen at an
// edge decides whether the cycle that follows is a write cycle (way_we set)
// or a stall cycle (way_we clear). beat_idx moves on after each write cycle.
module way_fill_decoder
    import cache_pkg::*;
#(
    parameter int WAYS   = cache_pkg::WAYS,
    parameter int IDX_W  = cache_pkg::IDX_W,
    parameter int BEATS  = cache_pkg::BEATS,
    parameter int BEAT_W = cache_pkg::BEAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_way,
    input  logic              req_en,
    input  logic              beat_stall,
    input  logic              abort,
    output logic [WAYS-1:0]   way_we,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              busy,
    output logic              fill_done,
`ifdef WAY_FILL_LAST_EN
    output logic [IDX_W-1:0]  last_way,
`endif
    output fill_state_t       fsm_state
);

    fill_state_t       state;
    logic [IDX_W-1:0]  way_q;
    logic [IDX_W-1:0]  way_next;
    logic              wr_now;
    logic              wr_next;
    logic              last_beat;
    logic [WAYS-1:0]   we_next;

    assign req_ready = (state == IDLE);
    assign fsm_state = state;
    assign wr_now    = |way_we;
    assign last_beat = (beat_idx == BEAT_W'(BEATS - 1));

    // Work out the way and whether the coming cycle writes a beat.
    always_comb begin
        way_next = way_q;
        wr_next  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_en) begin
                    way_next = req_way;
                    wr_next  = !beat_stall;
                end
            end
            FILL: begin
                if (!abort && !(wr_now && last_beat)) begin
                    wr_next = !beat_stall;
                end
            end
            default: begin
                wr_next = 1'b0;
            end
        endcase
    end

    way_onehot_dec #(
        .WAYS  (WAYS),
        .IDX_W (IDX_W)
    ) u_dec (
        .en     (wr_next),
        .idx    (way_next),
        .onehot (we_next)
    );

    // Fill FSM with registered outputs; abort takes priority over the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            way_q     <= '0;
            way_we    <= '0;
            beat_idx  <= '0;
            busy      <= 1'b0;
            fill_done <= 1'b0;
`ifdef WAY_FILL_LAST_EN
            last_way  <= '0;
`endif
        end else begin
            fill_done <= 1'b0;
            way_we    <= we_next;
            case (state)
                IDLE: begin
                    if (req_valid && req_en) begin
                        state    <= FILL;
                        way_q    <= req_way;
                        beat_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (abort) begin
                        state    <= IDLE;
                        beat_idx <= '0;
                        busy     <= 1'b0;
                    end else if (wr_now) begin
                        if (last_beat) begin
                            state     <= IDLE;
                            beat_idx  <= '0;
                            busy      <= 1'b0;
                            fill_done <= 1'b1;
`ifdef WAY_FILL_LAST_EN
                            last_way  <= way_q;
`endif
                        end else begin
                            beat_idx <= beat_idx + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
